// File: rtl/user_data_handshake_tx.sv
// Source side of a 4-phase req/ack handshake carrying one user data word into another
// clock domain; the returning acknowledge is synchronized locally before use.
module user_data_handshake_tx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] user_data_i,
    input  logic                  user_data_val_i,
    output logic                  user_data_rdy_o,
    output logic [DATA_WIDTH-1:0] user_data_tx_o,
    output logic                  req_user_data_tx_o,
    input  logic                  ack_user_data_rx_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam bit          TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W      = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CNT_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_LOW
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    req_q, req_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_user_data_rx_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            data_q    <= '0;
            req_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            req_q     <= req_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        req_d     = req_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (user_data_val_i) begin
                    data_d  = user_data_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A synchronized ack always wins over an expiring timeout.
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_LOW;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = WAIT_LOW;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (!TO_EN) begin
            cnt_d = '0;
        end
    end

    assign user_data_rdy_o    = (state_q == IDLE);
    assign busy_o             = (state_q != IDLE);
    assign user_data_tx_o     = data_q;
    assign req_user_data_tx_o = req_q;
    assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_user_data_handshake_tx.sv
// Self-checking bench: timestamp-based reference model, directed latency/timeout pins,
// and a randomized peer exercising ack delays with an in-order word scoreboard.
module tb_user_data_handshake_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_i;
    logic          val;
    logic          rdy;
    logic [DW-1:0] data_tx;
    logic          req;
    logic          ack = 1'b0;
    logic          busy;
    logic          tout;

    user_data_handshake_tx #(
        .DATA_WIDTH    (DW),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .user_data_i       (data_i),
        .user_data_val_i   (val),
        .user_data_rdy_o   (rdy),
        .user_data_tx_o    (data_tx),
        .req_user_data_tx_o(req),
        .ack_user_data_rx_i(ack),
        .busy_o            (busy),
        .timeout_o         (tout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 requesting, 2 waiting for ack low.
    int            m_phase = 0;
    logic          m_req   = 1'b0;
    logic          m_to    = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            cyc     = 0;
    int            acc_cyc = 0;
    int            n_acc   = 0;
    int            n_rise  = 0;
    logic [DW-1:0] exp_q[$];
    bit            ack_hist[$];

    always @(posedge clk or posedge rst) begin
        bit ack_seen;
        if (rst) begin
            m_phase = 0;
            m_req   = 1'b0;
            m_to    = 1'b0;
            m_data  = '0;
            ack_hist.delete();
            exp_q.delete();
        end else begin
            // The FSM acts on the ack value sampled SS edges earlier.
            ack_seen = 1'b0;
            if (ack_hist.size() >= SS) ack_seen = ack_hist[ack_hist.size() - SS];
            ack_hist.push_back(ack);
            if (ack_hist.size() > SS) void'(ack_hist.pop_front());
            m_to = 1'b0;
            if (m_phase == 0) begin
                if (val) begin
                    m_data  = data_i;
                    m_req   = 1'b1;
                    m_phase = 1;
                    acc_cyc = cyc;
                    exp_q.push_back(data_i);
                    n_acc++;
                end
            end else if (m_phase == 1) begin
                if (ack_seen) begin
                    m_req   = 1'b0;
                    m_phase = 2;
                end else if (cyc - acc_cyc == int'(TO)) begin
                    m_req   = 1'b0;
                    m_to    = 1'b1;
                    m_phase = 2;
                end
            end else begin
                if (!ack_seen) m_phase = 0;
            end
            cyc++;
        end
    end

    logic prev_req = 1'b0;

    always @(negedge clk) begin
        chk("rdy", 32'(rdy), 32'(m_phase == 0));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("req", 32'(req), 32'(m_req));
        chk("data_tx", 32'(data_tx), 32'(m_data));
        chk("timeout", 32'(tout), 32'(m_to));
        if (req && !prev_req) begin
            n_rise++;
            if (exp_q.size() == 0) chk("sb_extra_req", 32'(1), 32'(0));
            else chk("sb_word", 32'(data_tx), 32'(exp_q.pop_front()));
        end
        prev_req = req;
    end

    // Peer: mode 0 answers req with random delays, mode 1 holds ack at ack_force.
    int          peer_mode = 1;
    logic        ack_force = 1'b0;
    int unsigned dmax      = 0;
    int unsigned rise_wait = 0;
    int unsigned fall_wait = 0;

    always @(negedge clk) begin
        if (peer_mode == 0) begin
            if (!ack) begin
                if (req) begin
                    if (rise_wait == 0) ack = 1'b1;
                    else rise_wait--;
                end else begin
                    rise_wait = $urandom_range(0, dmax);
                end
            end else begin
                if (!req) begin
                    if (fall_wait == 0) ack = 1'b0;
                    else fall_wait--;
                end else begin
                    fall_wait = $urandom_range(0, dmax);
                end
            end
        end else begin
            ack = ack_force;
        end
    end

    task automatic accept(input logic [DW-1:0] d);
        data_i = d;
        val    = 1'b1;
        @(negedge clk);
        val = 1'b0;
    endtask

    // Negedges until the chosen output (0 req, 1 rdy) equals v; -1 if the bound expires.
    task automatic wait_sig(input int which, input logic v, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (((which == 0) ? req : rdy) == v) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        int n;
        int r0;
        int acc0;
        int pulses;
        int cycles;
        rst    = 1'b1;
        val    = 1'b0;
        data_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'(1));
        chk("rst_req", 32'(req), 32'(0));
        chk("rst_data", 32'(data_tx), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_timeout", 32'(tout), 32'(0));
        rst = 1'b0;

        // Reset in the middle of a request.
        accept(8'h3C);
        chk("t1_req_up", 32'(req), 32'(1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t1_req", 32'(req), 32'(0));
        chk("t1_rdy", 32'(rdy), 32'(1));
        chk("t1_data", 32'(data_tx), 32'(0));
        chk("t1_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic transfer with exact latencies.
        accept(8'hA5);
        chk("t2_data", 32'(data_tx), 32'hA5);
        chk("t2_req", 32'(req), 32'(1));
        chk("t2_rdy", 32'(rdy), 32'(0));
        chk("t2_busy", 32'(busy), 32'(1));
        repeat (2) @(negedge clk);
        ack_force = 1'b1;
        wait_sig(0, 1'b0, 50, n);
        chk("t2_req_fall_lat", 32'(n), 32'(SS + 1));
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        wait_sig(1, 1'b1, 50, n);
        chk("t2_rdy_lat", 32'(n), 32'(SS + 1));
        chk("t2_data_hold", 32'(data_tx), 32'hA5);

        // Back-to-back with val held high.
        peer_mode = 0;
        dmax      = 3;
        data_i    = 8'h01;
        val       = 1'b1;
        @(negedge clk);
        data_i = 8'h02;
        n = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy) begin
                n = i;
                break;
            end
            chk("t3_hold_01", 32'(data_tx), 32'h01);
        end
        chk("t3_rdy_seen", 32'(n >= 0), 32'(1));
        @(negedge clk);
        val = 1'b0;
        chk("t3_second", 32'(data_tx), 32'h02);
        wait_sig(1, 1'b1, 100, n);
        chk("t3_done", 32'(n > 0), 32'(1));

        // Timeout with ack tied low.
        peer_mode = 1;
        ack_force = 1'b0;
        repeat (2) @(negedge clk);
        accept(8'h77);
        wait_sig(0, 1'b0, 50, n);
        chk("t4_req_cycles", 32'(n), 32'(TO));
        chk("t4_pulse", 32'(tout), 32'(1));
        chk("t4_not_idle", 32'(rdy), 32'(0));
        @(negedge clk);
        chk("t4_pulse_end", 32'(tout), 32'(0));
        chk("t4_idle", 32'(rdy), 32'(1));

        // Stale ack stuck high: accept allowed, no timeout, parked in WAIT_LOW.
        ack_force = 1'b1;
        repeat (4) @(negedge clk);
        accept(8'h88);
        @(negedge clk);
        chk("t4b_req_drop", 32'(req), 32'(0));
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (tout) pulses++;
        end
        chk("t4b_no_timeout", 32'(pulses), 32'(0));
        chk("t4b_busy", 32'(busy), 32'(1));
        chk("t4b_rdy", 32'(rdy), 32'(0));
        ack_force = 1'b0;
        wait_sig(1, 1'b1, 50, n);
        chk("t4b_release", 32'(n), 32'(SS + 1));

        // Valid while busy is ignored.
        r0 = n_rise;
        accept(8'h5A);
        data_i = 8'hFF;
        val    = 1'b1;
        @(negedge clk);
        val = 1'b0;
        chk("t5_data", 32'(data_tx), 32'h5A);
        chk("t5_req", 32'(req), 32'(1));
        ack_force = 1'b1;
        wait_sig(0, 1'b0, 50, n);
        chk("t5_req_fall", 32'(n), 32'(SS + 1));
        ack_force = 1'b0;
        wait_sig(1, 1'b1, 50, n);
        chk("t5_rdy", 32'(n), 32'(SS + 1));
        chk("t5_one_req", 32'(n_rise - r0), 32'(1));
        chk("t5_data_end", 32'(data_tx), 32'h5A);

        // Random traffic with random peer delays.
        peer_mode = 0;
        dmax      = 20;
        acc0      = n_acc;
        cycles    = 0;
        while ((n_acc - acc0 < 200) && (cycles < 30000)) begin
            val    = ($urandom_range(0, 3) != 0);
            data_i = DW'($urandom);
            @(negedge clk);
            cycles++;
        end
        val = 1'b0;
        chk("t6_words", 32'(n_acc - acc0), 32'(200));
        wait_sig(1, 1'b1, 200, n);
        chk("t6_drain", 32'(n > 0), 32'(1));
        @(negedge clk);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'(0));
        chk("t6_req_edges", 32'(n_rise), 32'(n_acc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
